fft_frame_feeder: RTL and testbench
===================================

Name: fft_frame_feeder

Overview:
- Upstream stage of the 16-point MODE6 FFT top level.
- Accepts a valid/ready stream of 64-bit complex samples, packs them into one 16-sample frame, then issues the START pulse.
- Drives the load phase as 8 sample pairs on D0/D1: D0 = sample k, D1 = sample k+8.
- Holds off the next launch until the FFT returns DONE. The next frame may be prefetched while the FFT is busy.

Parameters:
- DW, 64, sample width ({re[31:0], im[31:0]}); passed through unchanged.
- NPAIR, 8, pairs per frame; frame length is 2*NPAIR = 16.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- S_VALID  in  1  input sample valid.
- S_READY  out  1  input sample ready.
- S_DATA  in  DW  input sample.
- S_LAST  in  1  marks the final sample of a frame.
- START  out  1  one-cycle launch pulse to the FFT.
- DONE  in  1  one-cycle completion pulse from the FFT.
- D0  out  DW  load-phase lower-half sample.
- D1  out  DW  load-phase upper-half sample.
- D_VALID  out  1  high during the 8 load cycles.
- BUSY  out  1  high from START until DONE is accepted.
- ERR_FRAME  out  1  sticky framing error; cleared only by RST.

Behaviour:
- Storage and counters:
  - 16 x DW register buffer.
  - 5-bit write count WCNT (0..16).
  - 3-bit feed index K.
  - FULL = (WCNT == 16).
- Reset: on RST=1 at a clock edge, registers take these values:
  - state = FILL, WCNT = 0, K = 0.
  - START = 0, D_VALID = 0, D0 = D1 = 0, BUSY = 0, ERR_FRAME = 0.
  - S_READY = 1 in the cycle after reset.
  - Buffer contents are don't-care.
  - Reset mid-frame or mid-feed discards everything; no START is issued.
- Accept rule: a sample is accepted when S_VALID & S_READY. It is written to buf[WCNT], then WCNT increments.
- S_READY = !FULL & (state == FILL or state == WAIT_DONE). It is 0 in LAUNCH and FEED.
- Framing, checked on each accepted sample:
  - S_LAST=1 with WCNT<15: the partial frame is dropped, WCNT := 0, ERR_FRAME := 1.
  - WCNT==15 with S_LAST=0: the sample is accepted, the frame completes, ERR_FRAME := 1.
- States:
  - FILL:
    - Accepts samples.
    - On the accept that makes WCNT=16, go to LAUNCH. START rises the next cycle, i.e. 1 cycle after the last accept.
    - DONE is ignored in FILL.
  - LAUNCH:
    - START=1 and BUSY=1 for exactly this one cycle.
    - Go to FEED with K=0.
  - FEED:
    - D_VALID=1, D0 = buf[K], D1 = buf[K+8] (registered outputs).
    - K increments each cycle, for 8 cycles (K = 0..7).
    - After K=7, D_VALID := 0, D0 = D1 := 0, WCNT := 0, go to WAIT_DONE.
    - First pair appears the cycle after START.
    - DONE arriving during FEED is latched and honoured at entry to WAIT_DONE.
  - WAIT_DONE:
    - BUSY=1.
    - Accepts the next frame (prefetch); framing rules apply.
    - On DONE (or a latched DONE), BUSY := 0. Then:
      - if FULL, go to LAUNCH next cycle;
      - else go to FILL.
    - If DONE coincides with the accept that fills the buffer, go to LAUNCH next cycle.
    - If the buffer is full and DONE has not arrived, S_READY=0 and the state holds indefinitely.
- D0/D1 are zero whenever D_VALID=0.
- No arithmetic is performed; data passes bit-exact.
- Throughput bound: 16 accept cycles, then 1 START cycle, then 8 FEED cycles, then FFT latency.

Test Plan:
- Reset, then stream samples 0x0..0xF (S_LAST on the 16th) with S_VALID held high:
  - START pulses 1 cycle after the 16th accept.
  - Next 8 cycles: D_VALID=1, D0/D1 = (0,8), (1,9) … (7,15).
  - S_READY=0 throughout LAUNCH and FEED.
- S_VALID toggled 1/0 on every cycle during the fill: all 16 samples land in order; the pair sequence is identical to the first test; START occurs exactly once.
- S_LAST asserted on the 5th sample, then a clean 16-sample frame 0x100..0x10F:
  - ERR_FRAME=1 and stays 1.
  - Only the clean frame is fed: D0/D1 = (0x100, 0x108) first.
- Prefetch: hold DONE low, stream a second frame during WAIT_DONE:
  - S_READY drops after 16 accepts.
  - Pulse DONE 20 cycles later: START fires on the cycle after DONE and the second frame is fed.
  - DONE coinciding with the 16th accept also gives START on the next cycle.
- Assert RST during FEED at K=3:
  - The next cycle shows D_VALID=0, D0=D1=0, BUSY=0, S_READY=1.
  - A new frame yields a normal START with no stale data.
- DONE pulsed while in FILL with WCNT=6: no effect; 10 more samples produce a normal launch.

Source files
------------

// File: rtl/fft_frame_feeder.sv
// Packs a valid/ready sample stream into a 16-sample frame, launches the FFT and feeds it as (k, k+8) pairs.
// START one cycle after the last accept, pairs on the 8 following cycles; S_READY low in LAUNCH/FEED and when a prefetched frame waits for DONE.
module fft_frame_feeder #(
  parameter int DW    = 64,
  parameter int NPAIR = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          S_VALID,
  output logic          S_READY,
  input  logic [DW-1:0] S_DATA,
  input  logic          S_LAST,
  output logic          START,
  input  logic          DONE,
  output logic [DW-1:0] D0,
  output logic [DW-1:0] D1,
  output logic          D_VALID,
  output logic          BUSY,
  output logic          ERR_FRAME
);

  localparam int NFRM = 2 * NPAIR;
  localparam int KW   = $clog2(NPAIR);
  localparam int AW   = KW + 1;
  localparam int CW   = $clog2(NFRM + 1);

  typedef enum logic [1:0] {FILL, LAUNCH, FEED, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic            err_q, err_d;
  logic            dlat_q, dlat_d;
  logic            dvld_q, dvld_d;
  logic [DW-1:0]   d0_q, d0_d, d1_q, d1_d;
  logic [DW-1:0]   mem_q [NFRM];

  logic full, last_slot, accept, short_last, fills, k_last;

  assign full       = (wcnt_q == CW'(NFRM));
  assign last_slot  = (wcnt_q == CW'(NFRM - 1));
  assign accept     = S_VALID & S_READY;
  assign short_last = accept & S_LAST & ~last_slot;
  assign fills      = accept & last_slot;
  assign k_last     = (k_q == KW'(NPAIR - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FILL;
      wcnt_q  <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      dlat_q  <= 1'b0;
      dvld_q  <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      k_q     <= k_d;
      err_q   <= err_d;
      dlat_q  <= dlat_d;
      dvld_q  <= dvld_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

  // Sample storage carries no reset; a dropped partial frame is simply overwritten.
  always_ff @(posedge CLK) begin
    if (accept && !short_last) begin
      mem_q[wcnt_q[AW-1:0]] <= S_DATA;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:      if (fills) state_d = LAUNCH;
      LAUNCH:    state_d = FEED;
      FEED:      if (k_last) state_d = WAIT_DONE;
      WAIT_DONE: if (DONE || dlat_q) state_d = (full || fills) ? LAUNCH : FILL;
      default:   state_d = FILL;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (short_last) begin
      wcnt_d = '0;
    end else if (accept) begin
      wcnt_d = wcnt_q + CW'(1);
    end
    if (state_q == FEED && k_last) begin
      wcnt_d = '0;
    end

    k_d = k_q;
    if (state_q == LAUNCH) begin
      k_d = '0;
    end else if (state_q == FEED) begin
      k_d = k_q + KW'(1);
    end

    // A DONE that arrives before WAIT_DONE is held until the feed finishes.
    dlat_d = dlat_q;
    if (state_q == WAIT_DONE) begin
      dlat_d = 1'b0;
    end else if ((state_q == LAUNCH || state_q == FEED) && DONE) begin
      dlat_d = 1'b1;
    end

    err_d  = err_q | short_last | (fills & ~S_LAST);

    dvld_d = (state_d == FEED);
    d0_d   = dvld_d ? mem_q[{1'b0, k_d}] : '0;
    d1_d   = dvld_d ? mem_q[{1'b1, k_d}] : '0;
  end

  always_comb begin
    S_READY   = ~full & (state_q == FILL || state_q == WAIT_DONE);
    START     = (state_q == LAUNCH);
    BUSY      = (state_q != FILL);
    D_VALID   = dvld_q;
    D0        = d0_q;
    D1        = d1_q;
    ERR_FRAME = err_q;
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: cycle table for the basic frame, directed corner sequences, then random traffic against a frame scoreboard.
module tb_fft_frame_feeder;
  localparam int DW = 64;

  logic          CLK = 1'b0;
  logic          RST, S_VALID, S_LAST, DONE;
  logic [DW-1:0] S_DATA, D0, D1;
  logic          S_READY, START, D_VALID, BUSY, ERR_FRAME;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  always #5 CLK = ~CLK;

  fft_frame_feeder #(.DW(DW), .NPAIR(8)) dut (
    .CLK(CLK), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .S_LAST(S_LAST), .START(START), .DONE(DONE), .D0(D0), .D1(D1),
    .D_VALID(D_VALID), .BUSY(BUSY), .ERR_FRAME(ERR_FRAME)
  );

  typedef struct {
    logic        vld;
    logic        last;
    logic [63:0] dat;
    logic        done;
    logic        exp_rdy;
    logic        exp_start;
    logic        exp_dvld;
    logic        exp_busy;
    logic [63:0] exp_d0;
    logic [63:0] exp_d1;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; S_VALID = 1'b0; S_LAST = 1'b0; DONE = 1'b0; S_DATA = '0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic pulse_done();
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
  endtask

  // Present one sample (optionally after an idle cycle) and hold it until accepted.
  task automatic send(input logic [63:0] d, input logic last, input bit gap);
    int n = 0;
    if (gap) begin
      S_VALID = 1'b0;
      tick();
    end
    S_VALID = 1'b1; S_DATA = d; S_LAST = last;
    while (!S_READY && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout", 1'b1, 1'b0);
    tick();
    S_VALID = 1'b0; S_LAST = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] base, input bit gap);
    for (int i = 0; i < 16; i++) send(base + 64'(i), i == 15, gap);
  endtask

  task automatic expect_feed(input logic [63:0] base, input bit now);
    int n = 0;
    while (!START && n < 100) begin
      tick();
      n++;
    end
    chk("start_seen", START, 1'b1);
    if (now) chk("start_delay", 64'(n), 64'd0);
    chk("launch_rdy", S_READY, 1'b0);
    chk("launch_busy", BUSY, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("feed_dvld", D_VALID, 1'b1);
      chk("feed_d0", D0, base + 64'(k));
      chk("feed_d1", D1, base + 64'(k + 8));
      chk("feed_rdy", S_READY, 1'b0);
      chk("feed_start", START, 1'b0);
      tick();
    end
    chk("post_dvld", D_VALID, 1'b0);
    chk("post_d0", D0, 64'd0);
    chk("post_busy", BUSY, 1'b1);
  endtask

  always @(negedge CLK) if (START) start_cnt++;

  // Frame-level reference: assemble accepted samples by the framing rules, then expect pairs (k, k+8).
  bit          mon_en = 1'b0;
  bit          m_err = 1'b0;
  int          feed_k = 0;
  int          exp_frames = 0;
  int          fed_frames = 0;
  logic [63:0] asm_q [$];
  logic [63:0] frm_q [$];

  always @(negedge CLK) begin
    if (mon_en) begin
      if (S_VALID && S_READY) begin
        if (S_LAST && asm_q.size() < 15) begin
          asm_q.delete();
          m_err = 1'b1;
        end else begin
          asm_q.push_back(S_DATA);
          if (asm_q.size() == 16) begin
            if (!S_LAST) m_err = 1'b1;
            foreach (asm_q[i]) frm_q.push_back(asm_q[i]);
            asm_q.delete();
            exp_frames++;
          end
        end
      end
      if (D_VALID) begin
        if (frm_q.size() < 16) begin
          chk("rand_unexpected_feed", 1'b1, 1'b0);
        end else begin
          chk("rand_d0", D0, frm_q[feed_k]);
          chk("rand_d1", D1, frm_q[feed_k + 8]);
          chk("rand_feed_rdy", S_READY, 1'b0);
          feed_k++;
          if (feed_k == 8) begin
            repeat (16) void'(frm_q.pop_front());
            feed_k = 0;
            fed_frames++;
          end
        end
      end else begin
        chk("rand_idle_zero", D0 | D1, 64'd0);
      end
    end
  end

  bit stop;
  int s0;
  int kind;
  int len;
  int n;
  bit lastbit;

  initial begin
    for (int i = 0; i < 27; i++) begin
      tbl[i] = '{vld: 1'b0, last: 1'b0, dat: 64'd0, done: 1'b0, exp_rdy: 1'b0, exp_start: 1'b0,
                 exp_dvld: 1'b0, exp_busy: 1'b0, exp_d0: 64'd0, exp_d1: 64'd0};
      if (i < 16) begin
        tbl[i].vld = 1'b1; tbl[i].dat = 64'(i); tbl[i].last = (i == 15); tbl[i].exp_rdy = 1'b1;
      end else if (i == 16) begin
        tbl[i].exp_start = 1'b1; tbl[i].exp_busy = 1'b1;
      end else if (i <= 24) begin
        tbl[i].exp_dvld = 1'b1; tbl[i].exp_busy = 1'b1;
        tbl[i].exp_d0 = 64'(i - 17); tbl[i].exp_d1 = 64'(i - 9);
      end else if (i == 25) begin
        tbl[i].exp_rdy = 1'b1; tbl[i].exp_busy = 1'b1; tbl[i].done = 1'b1;
      end else begin
        tbl[i].exp_rdy = 1'b1;
      end
    end

    do_reset();
    chk("reset_err", ERR_FRAME, 1'b0);

    // Back-to-back frame 0x0..0xF, launch, feed, DONE.
    for (int i = 0; i < 27; i++) begin
      S_VALID = tbl[i].vld; S_LAST = tbl[i].last; S_DATA = tbl[i].dat; DONE = tbl[i].done;
      chk($sformatf("tbl%0d_rdy", i), S_READY, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_start", i), START, tbl[i].exp_start);
      chk($sformatf("tbl%0d_dvld", i), D_VALID, tbl[i].exp_dvld);
      chk($sformatf("tbl%0d_busy", i), BUSY, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_d0", i), D0, tbl[i].exp_d0);
      chk($sformatf("tbl%0d_d1", i), D1, tbl[i].exp_d1);
      tick();
    end
    S_VALID = 1'b0; S_LAST = 1'b0; DONE = 1'b0;

    // Gapped fill: same pairs, exactly one START.
    s0 = start_cnt;
    send_frame(64'h0, 1'b1);
    expect_feed(64'h0, 1'b1);
    repeat (3) tick();
    chk("gapped_one_start", 64'(start_cnt - s0), 64'd1);
    pulse_done();
    chk("gapped_idle_busy", BUSY, 1'b0);

    // Short frame then clean frame.
    for (int i = 0; i < 5; i++) send(64'h200 + 64'(i), i == 4, 1'b0);
    chk("short_err", ERR_FRAME, 1'b1);
    chk("short_no_launch", BUSY, 1'b0);
    send_frame(64'h100, 1'b0);
    expect_feed(64'h100, 1'b1);
    chk("short_err_sticky", ERR_FRAME, 1'b1);

    // Prefetch while DONE withheld, release 20 cycles later.
    send_frame(64'h300, 1'b0);
    chk("prefetch_rdy_low", S_READY, 1'b0);
    s0 = start_cnt;
    repeat (20) tick();
    chk("prefetch_hold_start", 64'(start_cnt - s0), 64'd0);
    chk("prefetch_hold_busy", BUSY, 1'b1);
    pulse_done();
    chk("prefetch_start_next", START, 1'b1);
    expect_feed(64'h300, 1'b1);

    // DONE coinciding with the 16th prefetch accept.
    for (int i = 0; i < 15; i++) send(64'h400 + 64'(i), 1'b0, 1'b0);
    S_VALID = 1'b1; S_DATA = 64'h40F; S_LAST = 1'b1; DONE = 1'b1;
    chk("coinc_rdy", S_READY, 1'b1);
    tick();
    S_VALID = 1'b0; S_LAST = 1'b0; DONE = 1'b0;
    chk("coinc_start", START, 1'b1);
    expect_feed(64'h400, 1'b1);
    pulse_done();

    // Reset in the middle of a feed.
    send_frame(64'h500, 1'b0);
    chk("rstfeed_start", START, 1'b1);
    repeat (4) tick();
    chk("rstfeed_k3", D0, 64'h503);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstfeed_dvld", D_VALID, 1'b0);
    chk("rstfeed_d0", D0, 64'd0);
    chk("rstfeed_d1", D1, 64'd0);
    chk("rstfeed_busy", BUSY, 1'b0);
    chk("rstfeed_rdy", S_READY, 1'b1);
    chk("rstfeed_err", ERR_FRAME, 1'b0);
    send_frame(64'h600, 1'b0);
    expect_feed(64'h600, 1'b1);
    pulse_done();

    // DONE in FILL is ignored.
    s0 = start_cnt;
    for (int i = 0; i < 6; i++) send(64'h700 + 64'(i), 1'b0, 1'b0);
    pulse_done();
    chk("filldone_busy", BUSY, 1'b0);
    chk("filldone_start", 64'(start_cnt - s0), 64'd0);
    for (int i = 6; i < 16; i++) send(64'h700 + 64'(i), i == 15, 1'b0);
    expect_feed(64'h700, 1'b1);
    pulse_done();

    // Random traffic against the frame scoreboard.
    do_reset();
    m_err = 1'b0;
    stop = 1'b0;
    mon_en = 1'b1;
    fork
      begin
        for (int f = 0; f < 14; f++) begin
          kind = (f == 13) ? 0 : int'($urandom_range(0, 5));
          len = 16;
          lastbit = 1'b1;
          if (kind == 1) len = int'($urandom_range(1, 15));
          if (kind == 2) lastbit = 1'b0;
          for (int i = 0; i < len; i++)
            send({$urandom, $urandom}, lastbit && (i == len - 1), $urandom_range(0, 3) == 0);
        end
        n = 0;
        while ((frm_q.size() != 0 || asm_q.size() != 0) && n < 3000) begin
          tick();
          n++;
        end
        if (n >= 3000) chk("rand_drain_timeout", 1'b1, 1'b0);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(negedge CLK);
          if (START) begin
            repeat ($urandom_range(1, 40)) @(posedge CLK);
            #1;
            DONE = 1'b1;
            tick();
            DONE = 1'b0;
          end
        end
      end
    join
    repeat (5) tick();
    mon_en = 1'b0;
    chk("rand_err", ERR_FRAME, m_err);
    chk("rand_frames", 64'(fed_frames), 64'(exp_frames));
    chk("rand_end_busy", BUSY, 1'b0);
    chk("rand_end_rdy", S_READY, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
